// File: rtl/led_mode_sequencer.sv
// Mode/pause sequencer for the LED datapath. It passes the switches through in manual operation.
// In auto operation it steps through a playlist of modes, advancing on tick dwell expiry or a btn_next edge.
module led_mode_sequencer #(
    parameter int         NUM_ENTRIES = 4,
    parameter logic [7:0] PLAYLIST    = 8'b11100100,
    parameter logic [7:0] DWELL       = 8'd5
) (
    input  logic       clki,
    input  logic       reset,
    input  logic       tick,
    input  logic       auto_en,
    input  logic [1:0] sw_mode,
    input  logic       sw_pause,
    input  logic       btn_next,
    output logic [1:0] mode,
    output logic       pause,
    output logic       mode_chg,
    output logic [1:0] seq_idx
);

    typedef enum logic [1:0] {
        ST_MANUAL    = 2'd0,
        ST_AUTO_RUN  = 2'd1,
        ST_AUTO_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] LAST_IDX   = 2'(NUM_ENTRIES - 1);
    localparam logic [7:0] DWELL_LAST = DWELL - 8'd1;

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic       pause_q, pause_d;
    logic       mode_chg_q, mode_chg_d;
    logic [1:0] seq_idx_q, seq_idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       btn_q, btn_d;

    logic [1:0] entry [4];
    logic [1:0] next_idx;
    logic       btn_edge;
    logic       expire;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_entry
            assign entry[gi] = PLAYLIST[2*gi+1:2*gi];
        end
    endgenerate

    assign btn_edge = btn_next & ~btn_q;
    assign expire   = tick && (cnt_q == DWELL_LAST);
    assign next_idx = (seq_idx_q == LAST_IDX) ? 2'd0 : seq_idx_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pause_d    = pause_q;
        seq_idx_d  = seq_idx_q;
        cnt_d      = cnt_q;
        btn_d      = btn_next;
        mode_chg_d = 1'b0;

        if (!auto_en) begin
            state_d   = ST_MANUAL;
            mode_d    = sw_mode;
            pause_d   = sw_pause;
            seq_idx_d = 2'd0;
            cnt_d     = 8'd0;
        end else if (state_q == ST_MANUAL) begin
            // Entry into auto always starts from entry 0 with a full dwell.
            state_d   = sw_pause ? ST_AUTO_HOLD : ST_AUTO_RUN;
            mode_d    = entry[0];
            pause_d   = sw_pause;
            seq_idx_d = 2'd0;
            cnt_d     = 8'd0;
        end else begin
            state_d = sw_pause ? ST_AUTO_HOLD : ST_AUTO_RUN;
            pause_d = sw_pause;
            // A button edge coinciding with expiry still yields a single advance.
            if (btn_edge || (!sw_pause && expire)) begin
                seq_idx_d = next_idx;
                mode_d    = entry[next_idx];
                cnt_d     = 8'd0;
            end else if (!sw_pause && tick) begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        mode_chg_d = (mode_d != mode_q);
    end

    always_ff @(posedge clki) begin
        if (reset) begin
            state_q    <= ST_MANUAL;
            mode_q     <= 2'd0;
            pause_q    <= 1'b0;
            mode_chg_q <= 1'b0;
            seq_idx_q  <= 2'd0;
            cnt_q      <= 8'd0;
            btn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pause_q    <= pause_d;
            mode_chg_q <= mode_chg_d;
            seq_idx_q  <= seq_idx_d;
            cnt_q      <= cnt_d;
            btn_q      <= btn_d;
        end
    end

    assign mode     = mode_q;
    assign pause    = pause_q;
    assign mode_chg = mode_chg_q;
    assign seq_idx  = seq_idx_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer: instance a (4 entries, dwell 3) and instance b (3 entries, dwell 1).
module tb_led_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset, tick, auto_en, sw_pause, btn_next;
    logic [1:0] sw_mode;

    logic [1:0] a_mode, a_idx, b_mode, b_idx;
    logic       a_pause, a_chg, b_pause, b_chg;

    int n_cmp = 0;
    int n_mis = 0;

    always #10 clk = ~clk;

    led_mode_sequencer #(.NUM_ENTRIES(4), .PLAYLIST(8'b11100100), .DWELL(8'd3)) u_a (
        .clki(clk), .reset(reset), .tick(tick), .auto_en(auto_en),
        .sw_mode(sw_mode), .sw_pause(sw_pause), .btn_next(btn_next),
        .mode(a_mode), .pause(a_pause), .mode_chg(a_chg), .seq_idx(a_idx)
    );

    led_mode_sequencer #(.NUM_ENTRIES(3), .PLAYLIST(8'b11100100), .DWELL(8'd1)) u_b (
        .clki(clk), .reset(reset), .tick(tick), .auto_en(auto_en),
        .sw_mode(sw_mode), .sw_pause(sw_pause), .btn_next(btn_next),
        .mode(b_mode), .pause(b_pause), .mode_chg(b_chg), .seq_idx(b_idx)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One tick pulse; outputs are sampled right after the edge that saw it.
    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic idle_tick();
        pulse_tick();
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    logic [1:0] exp_run [8];
    logic       exp_chg [8];
    logic [1:0] exp_b   [4];

    initial begin
        exp_run = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
        exp_chg = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_b   = '{2'd1, 2'd2, 2'd0, 2'd1};

        reset = 1'b1; tick = 1'b0; auto_en = 1'b0;
        sw_mode = 2'd0; sw_pause = 1'b0; btn_next = 1'b0;
        step(); step();
        chk("rst_mode", a_mode, 0);
        chk("rst_pause", a_pause, 0);
        chk("rst_chg", a_chg, 0);
        chk("rst_idx", a_idx, 0);

        // Manual pass-through
        reset = 1'b0; sw_mode = 2'd2; sw_pause = 1'b1;
        step();
        chk("man_mode", a_mode, 2);
        chk("man_pause", a_pause, 1);
        chk("man_chg", a_chg, 1);
        step();
        chk("man_chg_end", a_chg, 0);
        tick = 1'b1; btn_next = 1'b1;
        step();
        tick = 1'b0;
        step();
        btn_next = 1'b0;
        chk("man_ign_mode", a_mode, 2);
        chk("man_ign_idx", a_idx, 0);
        chk("man_ign_chg", a_chg, 0);

        // Entry into auto and plain run with DWELL=3
        sw_pause = 1'b0; auto_en = 1'b1;
        step();
        chk("entry_mode", a_mode, 0);
        chk("entry_chg", a_chg, 1);
        chk("entry_pause", a_pause, 0);
        step();
        for (int k = 0; k < 8; k++) begin
            pulse_tick();
            chk($sformatf("run_t%0d_mode", k + 1), a_mode, exp_run[k]);
            chk($sformatf("run_t%0d_chg", k + 1), a_chg, exp_chg[k]);
            chk($sformatf("run_t%0d_idx", k + 1), a_idx, exp_run[k]);
            step();
            chk($sformatf("run_t%0d_chg_end", k + 1), a_chg, 0);
        end

        // Pause: two ticks, hold across five, resume from frozen count
        do_reset();
        chk("re_mode", a_mode, 0);
        idle_tick(); idle_tick();
        sw_pause = 1'b1;
        step();
        chk("hold_pause", a_pause, 1);
        for (int k = 0; k < 5; k++) begin
            idle_tick();
            chk($sformatf("hold_t%0d_mode", k), a_mode, 0);
            chk($sformatf("hold_t%0d_pause", k), a_pause, 1);
        end
        sw_pause = 1'b0;
        step();
        chk("resume_pause", a_pause, 0);
        chk("resume_mode", a_mode, 0);
        pulse_tick();
        chk("resume_adv_mode", a_mode, 1);
        chk("resume_adv_chg", a_chg, 1);
        step();

        // Held button: one advance, counter cleared
        idle_tick();
        btn_next = 1'b1;
        step();
        chk("btn_adv_mode", a_mode, 2);
        chk("btn_adv_chg", a_chg, 1);
        repeat (9) step();
        btn_next = 1'b0;
        step();
        chk("btn_held_mode", a_mode, 2);
        chk("btn_held_idx", a_idx, 2);
        idle_tick(); idle_tick();
        chk("btn_clr_t2", a_mode, 2);
        idle_tick();
        chk("btn_clr_t3", a_mode, 3);

        // Expiry and button edge together: single advance, wraps 3 -> 0
        idle_tick(); idle_tick();
        tick = 1'b1; btn_next = 1'b1;
        step();
        tick = 1'b0; btn_next = 1'b0;
        chk("sim_mode", a_mode, 0);
        chk("sim_idx", a_idx, 0);
        chk("sim_chg", a_chg, 1);
        step();
        idle_tick(); idle_tick();
        chk("sim_clr_t2", a_mode, 0);
        idle_tick();
        chk("sim_clr_t3", a_mode, 1);

        // Button in hold advances while paused
        sw_pause = 1'b1;
        step();
        btn_next = 1'b1;
        step();
        chk("hold_btn_mode", a_mode, 2);
        chk("hold_btn_pause", a_pause, 1);
        btn_next = 1'b0; sw_pause = 1'b0;
        step();

        // Reset mid-dwell with mode 2
        idle_tick();
        reset = 1'b1;
        step();
        chk("mid_rst_mode", a_mode, 0);
        chk("mid_rst_pause", a_pause, 0);
        chk("mid_rst_idx", a_idx, 0);
        chk("mid_rst_chg", a_chg, 0);
        reset = 1'b0;
        step();
        chk("mid_rst_entry_chg", a_chg, 0);
        idle_tick(); idle_tick();
        chk("mid_rst_t2", a_mode, 0);
        idle_tick();
        chk("mid_rst_t3", a_mode, 1);

        // Auto -> manual
        auto_en = 1'b0; sw_mode = 2'd3; sw_pause = 1'b1;
        step();
        chk("to_man_mode", a_mode, 3);
        chk("to_man_pause", a_pause, 1);
        chk("to_man_idx", a_idx, 0);
        chk("to_man_chg", a_chg, 1);

        // Instance b: three entries, every tick advances
        sw_pause = 1'b0; auto_en = 1'b1;
        do_reset();
        chk("b_entry_mode", b_mode, 0);
        for (int k = 0; k < 4; k++) begin
            idle_tick();
            chk($sformatf("b_t%0d_mode", k + 1), b_mode, exp_b[k]);
            chk($sformatf("b_t%0d_idx", k + 1), b_idx, exp_b[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
Control block that sits between the switch inputs and the LED mode-processing datapath. It drives the datapath's mode[1:0] and pause inputs. In manual operation it passes the registered switch values through. In auto operation it steps through a parameterised playlist of modes, holding each mode for a programmable number of ticks, and supports pause/hold and a "next" button for manual skipping.

Parameters:
NUM_ENTRIES  4            number of active playlist entries, legal range 1..4
PLAYLIST     8'b11100100  entry i = PLAYLIST[2i+1:2i]; default plays modes 0,1,2,3
DWELL        8'd5         ticks each entry is held, legal range 1..255

Ports:
clki      in   1  system clock (50 MHz)
reset     in   1  synchronous, active-high reset
tick      in   1  one-cycle strobe from the tick generator (1 Hz)
auto_en   in   1  1 = auto playlist operation, 0 = manual operation
sw_mode   in   2  manual mode select
sw_pause  in   1  pause request, honoured in both manual and auto operation
btn_next  in   1  skip button, level input, rising edge detected internally
mode      out  2  mode to the datapath, registered
pause     out  1  pause to the datapath, registered
mode_chg  out  1  one-cycle pulse in the cycle that mode takes a new value
seq_idx   out  2  current playlist index, registered

Behaviour:
- All inputs arrive already synchronised to clki. All outputs are registered.
- Reset, asserted for any cycle including mid-dwell: state=MANUAL, mode=0, pause=0, mode_chg=0, seq_idx=0, dwell counter=0, btn_next edge register=0.
- States:
  - MANUAL: active while auto_en=0.
  - AUTO_RUN: auto_en=1 and sw_pause=0.
  - AUTO_HOLD: auto_en=1 and sw_pause=1.
- MANUAL:
  - mode <= sw_mode and pause <= sw_pause, one cycle after the input changes.
  - tick and btn_next are ignored; seq_idx holds 0; counter holds 0.
- MANUAL -> AUTO_RUN/AUTO_HOLD, on the first cycle auto_en=1:
  - seq_idx <= 0, counter <= 0, mode <= PLAYLIST entry 0, pause <= sw_pause.
- AUTO_RUN:
  - pause=0.
  - On tick with counter < DWELL-1: counter increments.
  - On tick with counter == DWELL-1 (expiry): counter <= 0 and the index advances.
  - Advance rule: seq_idx <= (seq_idx == NUM_ENTRIES-1) ? 0 : seq_idx+1, and mode <= PLAYLIST[new idx], both in the same cycle.
- AUTO_HOLD:
  - pause=1; counter and seq_idx are frozen; tick is ignored.
  - Returning to AUTO_RUN resumes from the frozen counter value; the counter is not cleared.
- btn_next rising edge (btn_next=1 and the previous sample was 0), in AUTO_RUN or AUTO_HOLD:
  - Advance immediately and clear the counter.
  - In AUTO_HOLD the advance happens while pause stays 1.
- Simultaneous tick expiry and btn_next edge: advance exactly once; counter <= 0.
- AUTO -> MANUAL (auto_en falls): next cycle mode <= sw_mode, pause <= sw_pause, seq_idx <= 0, counter <= 0.
- mode_chg is 1 for exactly the one cycle in which the mode register's new value differs from its previous value, in any state. An advance that yields the same mode value (e.g. NUM_ENTRIES=1, or repeated playlist entries) produces no pulse.
- DWELL=1: every tick in AUTO_RUN advances.
- Counter width is 8 bits; it never exceeds DWELL-1.

Test Plan:
- Reset, then auto_en=0, sw_mode=2, sw_pause=1 -> mode=2 and pause=1 one cycle later; one mode_chg pulse; tick and btn_next have no effect.
- DWELL=3, default playlist, auto_en=1, 8 ticks -> mode sequence 0 (ticks 1-2), 1 at tick 3, 2 at tick 6; mode_chg pulses at ticks 3 and 6 only; seq_idx tracks mode.
- NUM_ENTRIES=3, DWELL=1, 4 ticks -> mode goes 1, 2, 0, 1 (wraps after idx 2); seq_idx never reaches 3.
- DWELL=3, after 2 ticks set sw_pause=1, apply 5 ticks, then clear sw_pause and apply 1 tick -> mode frozen at 0 and pause=1 during the hold; advance to mode 1 on the first tick after release.
- btn_next held high 10 cycles in AUTO_RUN -> exactly one advance and counter cleared. btn_next edge in the same cycle as an expiring tick -> a single advance (0 -> 1, not 2).
- Assert reset for one cycle mid-dwell with mode=2 in auto -> next cycle mode=0, pause=0, seq_idx=0, counter=0; auto restarts at entry 0 with a full dwell.
